// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Sequencing FSM for the multi-cycle MIPS-subset CPU. One memory port is
// shared by instruction fetch and data access, and one ALU is shared by PC
// increment, address calculation and execution. The controller walks each
// instruction through its states and drives every datapath select and enable.
// Memory accesses use a req/ready handshake guarded by a wait-cycle timeout.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-low
//   op_i         opcode field instr[31:26] from the instruction register
//   zero_i       ALU zero flag (branch decision)
//   mem_ready_i  memory completes the current access this cycle
//   mem_req_o / mem_read_o / mem_write_o   memory request and strobes
//   iord_o       memory address select: 0=PC, 1=ALUOut
//   ir_write_o   load instruction register
//   pc_write_o   load PC
//   pc_src_o     PC source: 00=ALU, 01=ALUOut, 10=jump target
//   reg_dst_o    write register select: 0=rt, 1=rd
//   reg_write_o  register file write enable
//   mem_to_reg_o writeback data: 0=ALUOut, 1=MDR
//   alu_src_a_o  ALU A: 0=PC, 1=rs
//   alu_src_b_o  ALU B: 00=rt, 01=4, 10=imm, 11=imm<<2
//   alu_op_o     000=add, 001=sub, 010=decode funct
//   state_o      current state encoding
//   illegal_o    one-cycle pulse on unsupported opcode
//   bus_err_o    one-cycle pulse on memory timeout
//   retired_o    count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  op_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        iord_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic [1:0]  pc_src_o,
    output logic        reg_dst_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_op_o,
    output logic [3:0]  state_o,
    output logic        illegal_o,
    output logic        bus_err_o,
    output logic [31:0] retired_o
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EXEC   = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // Last wait count tolerated before a memory access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [3:0]  state_r;
    logic [3:0]  state_next_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_next_s;
    logic [31:0] retired_r;
    logic        is_mem_s;
    logic        timeout_s;
    logic        retire_s;
    logic        illegal_s;

    assign state_o   = state_r;
    assign retired_o = retired_r;

    // Memory-state detection and timeout; ready in the final cycle wins.
    always_comb begin
        is_mem_s  = (state_r == S_FETCH) || (state_r == S_MEM_RD) ||
                    (state_r == S_MEM_WR);
        timeout_s = is_mem_s && !mem_ready_i && (wait_cnt_r >= WAIT_LAST);
        if (is_mem_s && !mem_ready_i && !timeout_s) begin
            wait_cnt_next_s = wait_cnt_r + 8'd1;
        end else begin
            wait_cnt_next_s = 8'd0;
        end
    end

    // Next-state logic plus retire and illegal-opcode detection.
    always_comb begin
        state_next_s = S_FETCH;
        retire_s     = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_next_s = S_DECODE;
                end else begin
                    // Timeout also lands here: re-fetch from the same PC.
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op_i)
                    OP_RTYPE:      state_next_s = S_R_EXEC;
                    OP_LW, OP_SW:  state_next_s = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
                    OP_ADDI:       state_next_s = S_I_EXEC;
                    OP_J:          state_next_s = S_JUMP;
                    default: begin
                        state_next_s = S_FETCH;
                        illegal_s    = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                if (op_i == OP_LW) begin
                    state_next_s = S_MEM_RD;
                end else if (op_i == OP_SW) begin
                    state_next_s = S_MEM_WR;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    state_next_s = S_MEM_WB;
                end else if (timeout_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    state_next_s = S_FETCH;
                    retire_s     = 1'b1;
                end else if (timeout_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEM_WR;
                end
            end
            S_R_EXEC: state_next_s = S_R_WB;
            S_R_WB: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_BRANCH: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_JUMP: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            S_I_EXEC: state_next_s = S_I_WB;
            S_I_WB: begin
                state_next_s = S_FETCH;
                retire_s     = 1'b1;
            end
            default: state_next_s = S_FETCH;
        endcase
    end

    // Moore output decode; everything is held at 0 while reset is asserted.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'b00;
        reg_dst_o    = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        illegal_o    = 1'b0;
        bus_err_o    = 1'b0;
        if (rst_i) begin
            illegal_o = illegal_s;
            bus_err_o = timeout_s;
            case (state_r)
                S_FETCH: begin
                    mem_req_o   = 1'b1;
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = 2'b11;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEM_RD: begin
                    mem_req_o  = 1'b1;
                    mem_read_o = 1'b1;
                    iord_o     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req_o   = 1'b1;
                    // The write strobe is withdrawn in the abandoning cycle.
                    mem_write_o = !timeout_s;
                    iord_o      = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 3'b010;
                end
                S_R_WB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 3'b001;
                    pc_src_o    = 2'b01;
                    if (op_i == OP_BEQ) begin
                        pc_write_o = zero_i;
                    end else if (op_i == OP_BNE) begin
                        pc_write_o = !zero_i;
                    end else begin
                        pc_write_o = 1'b0;
                    end
                end
                S_JUMP: begin
                    pc_src_o   = 2'b10;
                    pc_write_o = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_I_WB: begin
                    reg_write_o = 1'b1;
                end
                default: begin
                    mem_req_o = 1'b0;
                end
            endcase
        end else begin
            illegal_o = 1'b0;
            bus_err_o = 1'b0;
        end
    end

    // State, wait counter and retired-instruction counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= S_FETCH;
            wait_cnt_r <= 8'd0;
            retired_r  <= 32'd0;
        end else begin
            state_r    <= state_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            if (retire_s) begin
                retired_r <= retired_r + 32'd1;
            end else begin
                retired_r <= retired_r;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl (TIMEOUT=4). Each test task queues
// per-cycle entries (inputs to drive plus the expected state, qualified
// enables, pulses and retired count); run_queue drives them one cycle at a
// time and compares the DUT against them.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op = 6'h00;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        reg_dst, reg_write, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic        illegal, bus_err;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_retired = 32'd0;

    typedef struct {
        logic [3:0]  st;
        logic        rdy;
        logic [5:0]  op;
        logic        zero;
        logic        irw;
        logic        pcw;
        logic        ill;
        logic        err;
        logic        frc;
        logic [31:0] ret;
    } cyc_t;

    cyc_t sbq[$];

    multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk_i(clk), .rst_i(rst), .op_i(op), .zero_i(zero),
        .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .iord_o(iord), .ir_write_o(ir_write),
        .pc_write_o(pc_write), .pc_src_o(pc_src), .reg_dst_o(reg_dst),
        .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
        .state_o(state), .illegal_o(illegal), .bus_err_o(bus_err),
        .retired_o(retired)
    );

    always #5 clk = ~clk;

    // Control vector order:
    // {req, rd, wr, iord, irw, pcw, pc_src, reg_dst, reg_write, mem_to_reg,
    //  alu_a, alu_b, alu_op, illegal, bus_err}
    function automatic logic [18:0] exp_ctl(input cyc_t e);
        logic req, rd, wr, io, rdst, rw, m2r, a;
        logic [1:0] ps, b;
        logic [2:0] ao;
        req = 1'b0; rd = 1'b0; wr = 1'b0; io = 1'b0; rdst = 1'b0; rw = 1'b0;
        m2r = 1'b0; a = 1'b0; ps = 2'b00; b = 2'b00; ao = 3'b000;
        case (e.st)
            4'd0:  begin req = 1'b1; rd = 1'b1; b = 2'b01; end
            4'd1:  begin b = 2'b11; end
            4'd2:  begin a = 1'b1; b = 2'b10; end
            4'd3:  begin req = 1'b1; rd = 1'b1; io = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin req = 1'b1; wr = ~e.err; io = 1'b1; end
            4'd6:  begin a = 1'b1; ao = 3'b010; end
            4'd7:  begin rw = 1'b1; rdst = 1'b1; end
            4'd8:  begin a = 1'b1; ao = 3'b001; ps = 2'b01; end
            4'd9:  begin ps = 2'b10; end
            4'd10: begin a = 1'b1; b = 2'b10; end
            4'd11: begin rw = 1'b1; end
            default: begin req = 1'b0; end
        endcase
        return {req, rd, wr, io, e.irw, e.pcw, ps, rdst, rw, m2r, a, b, ao,
                e.ill, e.err};
    endfunction

    function automatic logic [18:0] got_ctl();
        return {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
                reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                illegal, bus_err};
    endfunction

    task automatic push(input logic [3:0] st, input logic rdy,
                        input logic [5:0] o, input logic z, input logic irw,
                        input logic pcw, input logic ill, input logic err,
                        input logic frc);
        cyc_t e;
        e.st = st; e.rdy = rdy; e.op = o; e.zero = z; e.irw = irw;
        e.pcw = pcw; e.ill = ill; e.err = err; e.frc = frc;
        e.ret = exp_retired;
        sbq.push_back(e);
    endtask

    task automatic push_fetch(input logic rdy);
        push(4'd0, rdy, 6'h00, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_queue();
        cyc_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            mem_ready = e.rdy; zero = e.zero; op = e.op;
            #1;
            checks++;
            if (state !== e.st) begin
                errors++;
                $display("FAIL state: got %0d expected %0d", state, e.st);
            end
            checks++;
            if (got_ctl() !== exp_ctl(e)) begin
                errors++;
                $display("FAIL ctl in state %0d: got %b expected %b",
                         e.st, got_ctl(), exp_ctl(e));
            end
            checks++;
            if (retired !== e.ret) begin
                errors++;
                $display("FAIL retired: got %h expected %h", retired, e.ret);
            end
            if (e.frc) begin
                force dut.retired_r = 32'hFFFF_FFFF;
                #1;
                release dut.retired_r;
                #1;
                checks++;
                if (retired !== 32'hFFFF_FFFF) begin
                    errors++;
                    $display("FAIL preload: got %h expected ffffffff", retired);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1; op = 6'h00;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("FAIL reset state: got %0d expected 0", state);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL reset retired: got %h expected 0", retired);
        end
        checks++;
        if (got_ctl() !== 19'd0) begin
            errors++; $display("FAIL reset ctl: got %b expected 0", got_ctl());
        end
        mem_ready = 1'b0;
        rst = 1'b1;
        exp_retired = 32'd0;
    endtask

    task automatic test_rtype();
        push_fetch(1'b1);
        push(4'd1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd6, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd7, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_retired++;
        run_queue();
    endtask

    task automatic test_addi();
        push_fetch(1'b1);
        push(4'd1, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd10, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd11, 1'b0, 6'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_retired++;
        run_queue();
    endtask

    task automatic test_lw_wait();
        push_fetch(1'b1);
        push(4'd1, 1'b0, 6'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd2, 1'b0, 6'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            push(4'd3, 1'b0, 6'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Ready on the last tolerated wait cycle must complete the read.
        push(4'd3, 1'b1, 6'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd4, 1'b0, 6'h23, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_retired++;
        run_queue();
    endtask

    task automatic test_branch();
        logic [5:0] bop [4];
        logic       bz  [4];
        logic       bpw [4];
        bop = '{6'h04, 6'h04, 6'h05, 6'h05};
        bz  = '{1'b1, 1'b0, 1'b0, 1'b1};
        bpw = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            push_fetch(1'b1);
            push(4'd1, 1'b0, bop[i], bz[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            push(4'd8, 1'b1, bop[i], bz[i], 1'b0, bpw[i], 1'b0, 1'b0, 1'b0);
            exp_retired++;
        end
        run_queue();
    endtask

    task automatic test_sw();
        push_fetch(1'b1);
        push(4'd1, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd2, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd5, 1'b1, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_retired++;
        run_queue();
    endtask

    task automatic test_timeout();
        // Fetch timeout: three waits, bus error on the fourth, no retire.
        for (int i = 0; i < 3; i++) push_fetch(1'b0);
        push(4'd0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Re-fetch: ready on the fourth cycle wins over timeout.
        for (int i = 0; i < 3; i++) push_fetch(1'b0);
        push_fetch(1'b1);
        push(4'd1, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd9, 1'b0, 6'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_retired++;
        // Store timeout: write strobe dropped, no retire.
        push_fetch(1'b1);
        push(4'd1, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd2, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            push(4'd5, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd5, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_queue();
    endtask

    task automatic test_illegal();
        push_fetch(1'b1);
        push(4'd1, 1'b1, 6'h3F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_queue();
    endtask

    task automatic test_wrap();
        push_fetch(1'b1);
        push(4'd1, 1'b0, 6'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_retired = 32'hFFFF_FFFF;
        push(4'd9, 1'b0, 6'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_retired++;
        run_queue();
    endtask

    task automatic test_reset_mid();
        push_fetch(1'b1);
        push(4'd1, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd2, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(4'd5, 1'b0, 6'h2B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_queue();
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL mid-reset strobe: got wr=%b req=%b expected 0 0",
                     mem_write, mem_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++; $display("FAIL mid-reset state: got %0d expected 0", state);
        end
        checks++;
        if (retired !== 32'd0) begin
            errors++; $display("FAIL mid-reset retired: got %h expected 0", retired);
        end
        mem_ready = 1'b0;
        rst = 1'b1;
        exp_retired = 32'd0;
        test_rtype();
        push_fetch(1'b0);
        run_queue();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_lw_wait();
        test_branch();
        test_sw();
        test_timeout();
        test_illegal();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
